pc_sequencer: RTL

Parametrised program counter with a hardware return-address (link) stack, replacing the single-register PC. It computes the next instruction address each cycle from sequential increment, PC-relative branch, absolute jump, call (with automatic push of the return address), return (pop), or a trap vector. It sits between the control unit and instruction memory. `instruction_address` drives the fetch port directly.

---
 rtl/pc_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Program counter with a hardware return-address (link) stack. Each falling
// clock edge computes the next fetch address from one of: sequential
// increment, PC-relative branch, absolute jump, call (pushes the return
// address), return (pops it), or the trap vector.
//
// Ports:
//   clock               in  : system clock, all state updates on the falling edge
//   reset_n             in  : asynchronous active-low reset
//   halt                in  : stall, all state holds while high
//   trap                in  : jump to TRAP_VECTOR
//   write_condition     in  : condition check passed for the current instruction
//   should_branch       in  : current instruction is a control transfer
//   branch_mode         in  : 00 relative, 01 absolute, 10 call, 11 return
//   branch_value        in  : signed offset (00/10) or absolute target (01)
//   instruction_address out : current PC, drives the fetch port
//   link_top            out : newest link-stack entry, 0 when empty
//   stack_count         out : number of valid link-stack entries
//   stack_overflow      out : sticky, a call pushed onto a full stack
//   stack_underflow     out : sticky, a return found the stack empty
module pc_sequencer #(
  parameter int                ADDR_W      = 32,
  parameter int                STEP        = 1,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
  parameter logic [ADDR_W-1:0] TRAP_VECTOR = ADDR_W'(32'd8)
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 halt,
  input  logic                                 trap,
  input  logic                                 write_condition,
  input  logic                                 should_branch,
  input  logic [1:0]                           branch_mode,
  input  logic [ADDR_W-1:0]                    branch_value,
  output logic [ADDR_W-1:0]                    instruction_address,
  output logic [ADDR_W-1:0]                    link_top,
  output logic [$clog2(STACK_DEPTH+1)-1:0]     stack_count,
  output logic                                 stack_overflow,
  output logic                                 stack_underflow
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  localparam logic [1:0] MODE_REL  = 2'b00;
  localparam logic [1:0] MODE_ABS  = 2'b01;
  localparam logic [1:0] MODE_CALL = 2'b10;
  localparam logic [1:0] MODE_RET  = 2'b11;

  // Circular-buffer pointer arithmetic; works for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(STACK_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1'b1);
    end
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    if (p == '0) begin
      return PTR_W'(STACK_DEPTH - 1);
    end else begin
      return p - PTR_W'(1'b1);
    end
  endfunction

  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] link_top_q, link_top_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic [ADDR_W-1:0] seq_s;
  logic              take_s;
  logic              push_s;
  logic [PTR_W-1:0]  ptr_dec_s;
  logic [PTR_W-1:0]  ptr_dec2_s;

  assign seq_s      = pc_q + ADDR_W'(STEP);
  assign take_s     = write_condition & should_branch;
  assign ptr_dec_s  = ptr_dec(ptr_q);
  assign ptr_dec2_s = ptr_dec(ptr_dec_s);

  // Next-state selection by priority: halt, trap, taken branch, sequential.
  always_comb begin
    pc_d       = pc_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    link_top_d = link_top_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    push_s     = 1'b0;
    if (halt) begin
      pc_d = pc_q;
    end else if (trap) begin
      pc_d = TRAP_VECTOR;
    end else if (take_s) begin
      case (branch_mode)
        MODE_REL: begin
          // Offset is already ADDR_W wide, so two's-complement add wraps correctly.
          pc_d = seq_s + branch_value;
        end
        MODE_ABS: begin
          pc_d = branch_value;
        end
        MODE_CALL: begin
          pc_d       = seq_s + branch_value;
          push_s     = 1'b1;
          ptr_d      = ptr_inc(ptr_q);
          link_top_d = seq_s;
          // Full stack: the oldest slot is overwritten, count stays saturated.
          if (count_q == CNT_W'(STACK_DEPTH)) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1'b1);
          end
        end
        MODE_RET: begin
          if (count_q != '0) begin
            pc_d    = stack_q[ptr_dec_s];
            ptr_d   = ptr_dec_s;
            count_d = count_q - CNT_W'(1'b1);
            // The new top is the entry two below the current pointer.
            if (count_q > CNT_W'(1'b1)) begin
              link_top_d = stack_q[ptr_dec2_s];
            end else begin
              link_top_d = '0;
            end
          end else begin
            pc_d  = seq_s;
            unf_d = 1'b1;
          end
        end
        default: begin
          pc_d = seq_s;
        end
      endcase
    end else begin
      pc_d = seq_s;
    end
  end

  // PC, pointer, count, link-top and sticky flag registers.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_ADDR;
      ptr_q      <= '0;
      count_q    <= '0;
      link_top_q <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      link_top_q <= link_top_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Link-stack storage: a push writes the return address at the pointer.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      if (push_s) begin
        stack_q[ptr_q] <= seq_s;
      end
    end
  end

  assign instruction_address = pc_q;
  assign link_top            = link_top_q;
  assign stack_count         = count_q;
  assign stack_overflow      = ovf_q;
  assign stack_underflow     = unf_q;

endmodule
